// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states, port ids,
// the latched request record and the access legality check.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE_RD = 3'd1,
      LOAD_RSP = 3'd2,
      STORE_WR = 3'd3,
      MERGE_WR = 3'd4,
      ERR_RSP  = 3'd5
   } state_e;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_D = 1'b1
   } port_e;

   typedef struct packed {
      port_e       port;
      logic        we;
      size_e       size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Illegal size, or an address not aligned to the access size.
   function automatic logic access_err(input size_e size, input logic [1:0] addr_lo);
      logic err_s;
      case (size)
         SZ_BYTE: err_s = 1'b0;
         SZ_HALF: err_s = addr_lo[0];
         SZ_WORD: err_s = (addr_lo != 2'b00);
         default: err_s = 1'b1;
      endcase
      return err_s;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a memory word and a sub-word access: load
// extraction, read-modify-write merge and the misalignment flag.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word,
   output logic        misalign
);

   logic [4:0]  shift_s;
   logic [31:0] lane_s;
   logic [31:0] mask_s;

   assign shift_s  = {addr_lo, 3'b000};
   assign lane_s   = old_word >> shift_s;
   assign misalign = access_err(size, addr_lo);

   // Select the addressed lane for loads and build the write mask for merges.
   always_comb begin
      load_data = 32'h0000_0000;
      mask_s    = 32'h0000_0000;
      case (size)
         SZ_BYTE: begin
            load_data = {24'h00_0000, lane_s[7:0]};
            mask_s    = 32'h0000_00FF << shift_s;
         end
         SZ_HALF: begin
            load_data = {16'h0000, lane_s[15:0]};
            mask_s    = 32'h0000_FFFF << shift_s;
         end
         SZ_WORD: begin
            load_data = old_word;
            mask_s    = 32'hFFFF_FFFF;
         end
         default: begin
            load_data = 32'h0000_0000;
            mask_s    = 32'h0000_0000;
         end
      endcase
      merged_word = (old_word & ~mask_s) | ((wdata << shift_s) & mask_s);
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core C, debug D) arbiter and access sequencer in front of the
// single-port data BRAM; sub-word stores are done as read-modify-write.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int NUM_WORDS    = 1024,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req_valid,
   output logic        c_req_ready,
   input  logic        c_req_we,
   input  logic [1:0]  c_req_size,
   input  logic [31:0] c_req_addr,
   input  logic [31:0] c_req_wdata,
   output logic        c_rsp_valid,
   output logic [31:0] c_rsp_rdata,
   output logic        c_rsp_err,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic        d_req_we,
   input  logic [1:0]  d_req_size,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_rdata,
   output logic        d_rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write_en,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_data_out
);

   localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_V   = CNT_W'(STARVE_LIMIT);
   localparam logic [31:0]      ADDR_MASK = 32'(NUM_WORDS * 4 - 1);

   state_e           state_r, state_next_s;
   req_t             req_r, req_in_s, align_req_s;
   logic [CNT_W-1:0] starve_cnt_r;
   logic             idle_s, grant_d_s;
   logic             rsp_valid_s, rsp_err_s;
   logic [31:0]      rsp_rdata_s, load_data_s, merged_s;
   logic             misalign_s;

   assign idle_s      = (state_r == IDLE) && !rst;
   assign grant_d_s   = d_req_valid && ((starve_cnt_r >= LIMIT_V) || !c_req_valid);
   assign c_req_ready = idle_s && c_req_valid && !grant_d_s;
   assign d_req_ready = idle_s && grant_d_s;

   // Request presented by the port that wins arbitration this cycle.
   always_comb begin
      req_in_s = '0;
      if (grant_d_s) begin
         req_in_s = '{port: PORT_D, we: d_req_we, size: size_e'(d_req_size),
                      addr: d_req_addr, wdata: d_req_wdata};
      end else begin
         req_in_s = '{port: PORT_C, we: c_req_we, size: size_e'(c_req_size),
                      addr: c_req_addr, wdata: c_req_wdata};
      end
   end

   // In IDLE the lane checker vets the incoming request; afterwards the latched one.
   assign align_req_s = (state_r == IDLE) ? req_in_s : req_r;

   dmem_lane_align u_align (
      .size        (align_req_s.size),
      .addr_lo     (align_req_s.addr[1:0]),
      .old_word    (mem_data_out),
      .wdata       (align_req_s.wdata),
      .load_data   (load_data_s),
      .merged_word (merged_s),
      .misalign    (misalign_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_next_s;
   end

   // Latch the accepted request for the duration of the transaction.
   always_ff @(posedge clk) begin
      if (rst)                              req_r <= '0;
      else if (c_req_ready || d_req_ready)  req_r <= req_in_s;
   end

   // Count cycles D waits while valid, saturating; cleared when D is accepted.
   always_ff @(posedge clk) begin
      if (rst)                                     starve_cnt_r <= '0;
      else if (d_req_ready)                        starve_cnt_r <= '0;
      else if (d_req_valid && starve_cnt_r < LIMIT_V) starve_cnt_r <= starve_cnt_r + CNT_W'(1);
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (c_req_ready || d_req_ready) begin
               if (misalign_s)                                 state_next_s = ERR_RSP;
               else if (req_in_s.we && req_in_s.size == SZ_WORD) state_next_s = STORE_WR;
               else                                            state_next_s = ISSUE_RD;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE_RD: state_next_s = req_r.we ? MERGE_WR : LOAD_RSP;
         LOAD_RSP, STORE_WR, MERGE_WR, ERR_RSP: state_next_s = IDLE;
         default:  state_next_s = IDLE;
      endcase
   end

   // State-decoded memory strobes and response; everything is quiet while rst is high.
   always_comb begin
      mem_addr       = 32'h0000_0000;
      mem_read       = 1'b0;
      mem_write_en   = 1'b0;
      mem_write_data = 32'h0000_0000;
      rsp_valid_s    = 1'b0;
      rsp_err_s      = 1'b0;
      rsp_rdata_s    = 32'h0000_0000;
      if (!rst) begin
         case (state_r)
            ISSUE_RD: begin
               mem_read = 1'b1;
               mem_addr = req_r.addr & ADDR_MASK;
            end
            LOAD_RSP: begin
               rsp_valid_s = 1'b1;
               rsp_rdata_s = load_data_s;
            end
            STORE_WR: begin
               mem_addr       = req_r.addr & ADDR_MASK;
               mem_write_en   = 1'b1;
               mem_write_data = req_r.wdata;
               rsp_valid_s    = 1'b1;
            end
            MERGE_WR: begin
               mem_addr       = req_r.addr & ADDR_MASK;
               mem_write_en   = 1'b1;
               mem_write_data = merged_s;
               rsp_valid_s    = 1'b1;
            end
            ERR_RSP: begin
               rsp_valid_s = 1'b1;
               rsp_err_s   = 1'b1;
            end
            default: rsp_valid_s = 1'b0;
         endcase
      end else begin
         rsp_valid_s = 1'b0;
      end
   end

   assign c_rsp_valid = rsp_valid_s && (req_r.port == PORT_C);
   assign c_rsp_err   = rsp_err_s   && (req_r.port == PORT_C);
   assign c_rsp_rdata = (req_r.port == PORT_C) ? rsp_rdata_s : 32'h0000_0000;
   assign d_rsp_valid = rsp_valid_s && (req_r.port == PORT_D);
   assign d_rsp_err   = rsp_err_s   && (req_r.port == PORT_D);
   assign d_rsp_rdata = (req_r.port == PORT_D) ? rsp_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: BRAM model, transaction-level reference (latency counts,
// byte-wise memory image), directed scenarios then randomized two-port traffic.
module tb_dmem_arbiter;

   localparam int          NUM_WORDS    = 1024;
   localparam int          STARVE_LIMIT = 8;
   localparam logic [31:0] ADDR_MASK    = 32'(NUM_WORDS * 4 - 1);

   typedef struct packed {
      bit        port;
      bit        we;
      bit [1:0]  size;
      bit [31:0] addr;
      bit [31:0] wdata;
   } req_s;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_err;
   logic [1:0]  c_req_size;
   logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata;
   logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
   logic [1:0]  d_req_size;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
   logic [31:0] mem_addr, mem_write_data, mem_data_out;
   logic        mem_read, mem_write_en;

   dmem_arbiter #(.NUM_WORDS(NUM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
      .c_req_size(c_req_size), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
      .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_size(d_req_size), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 1)  return 32'hDEAD_BEEF;
      if (i == 2)  return 32'hCAFE_BABE;
      if (i == 10) return 32'd50;
      return 32'(i) * 32'h9E37_79B1;
   endfunction

   // DataMemory stand-in: one-cycle read latency, power-up image loaded on init_en.
   bit init_en = 1'b1;
   logic [31:0] bram [0:NUM_WORDS-1];
   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < NUM_WORDS; i++) bram[i] <= init_word(i);
      end else begin
         if (mem_write_en) bram[mem_addr[11:2]] <= mem_write_data;
         if (mem_read)     mem_data_out <= bram[mem_addr[11:2]];
      end
   end

   // Reference model state
   bit [31:0] ref_mem [0:NUM_WORDS-1];
   req_s      cq[$], dq[$], cur;
   bit        act, cur_err, rst_hold;
   int        k, lat, starve, cyc, rst_at;
   int        acc_port_log[$], acc_cyc_log[$];
   int        c_rsp_cyc, d_rsp_cyc, c_rsp_n, d_rsp_n, rd_n, wr_n;
   logic [31:0] c_last_rdata, w_last;
   logic        c_last_err;
   int        checks_cnt, errors_cnt;

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks_cnt++;
      if (actual !== expected) begin
         errors_cnt++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   function automatic int nbytes(input bit [1:0] size);
      return 1 << size;
   endfunction

   function automatic bit ref_err(input req_s r);
      if (r.size == 2'd3) return 1'b1;
      return (r.addr % nbytes(r.size)) != 0;
   endfunction

   function automatic bit [31:0] ref_load(input bit [31:0] w, input req_s r);
      bit [31:0] v  = 32'd0;
      int        lo = int'(r.addr % 4);
      for (int b = 0; b < nbytes(r.size); b++) v[8*b +: 8] = w[8*(lo+b) +: 8];
      return v;
   endfunction

   function automatic bit [31:0] ref_store(input bit [31:0] w, input req_s r);
      bit [31:0] v  = w;
      int        lo = int'(r.addr % 4);
      for (int b = 0; b < nbytes(r.size); b++) v[8*(lo+b) +: 8] = r.wdata[8*b +: 8];
      return v;
   endfunction

   function automatic req_s mk(input bit we, input bit [1:0] size, input bit [31:0] addr,
                               input bit [31:0] wdata);
      req_s r;
      r.port = 1'b0; r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   // One clock: drive, check at negedge against the model, advance the model.
   task automatic tick();
      req_s        cr, dr;
      bit          cv, dv, gd, r, exp_cr, exp_dr, exp_rsp, exp_rd, exp_wr, store_rsp;
      logic [31:0] exp_rdata;
      int          idx;
      cv = cq.size() > 0;
      dv = dq.size() > 0;
      cr = cv ? cq[0] : '0;
      dr = dv ? dq[0] : '0;
      r  = rst_hold || (cyc == rst_at);
      rst = r;
      c_req_valid = cv; c_req_we = cr.we; c_req_size = cr.size; c_req_addr = cr.addr; c_req_wdata = cr.wdata;
      d_req_valid = dv; d_req_we = dr.we; d_req_size = dr.size; d_req_addr = dr.addr; d_req_wdata = dr.wdata;
      @(negedge clk);
      gd        = dv && (starve >= STARVE_LIMIT || !cv);
      exp_cr    = !r && !act && cv && !gd;
      exp_dr    = !r && !act && gd;
      exp_rsp   = !r && act && (k == lat);
      exp_rd    = !r && act && (k == 1) && (lat == 2);
      exp_wr    = exp_rsp && cur.we && !cur_err;
      store_rsp = exp_rsp && cur.we && !cur_err;
      idx       = int'(cur.addr[11:2]);
      exp_rdata = (exp_rsp && !cur.we && !cur_err) ? ref_load(ref_mem[idx], cur) : 32'd0;

      check_eq("c_ready", c_req_ready, exp_cr);
      check_eq("d_ready", d_req_ready, exp_dr);
      check_eq("c_rsp_valid", c_rsp_valid, exp_rsp && !cur.port);
      check_eq("d_rsp_valid", d_rsp_valid, exp_rsp && cur.port);
      check_eq("c_rsp_err", c_rsp_err, exp_rsp && !cur.port && cur_err);
      check_eq("d_rsp_err", d_rsp_err, exp_rsp && cur.port && cur_err);
      if (!(store_rsp && !cur.port)) check_eq("c_rdata", c_rsp_rdata, cur.port ? 32'd0 : exp_rdata);
      if (!(store_rsp && cur.port))  check_eq("d_rdata", d_rsp_rdata, cur.port ? exp_rdata : 32'd0);
      check_eq("mem_read", mem_read, exp_rd);
      check_eq("mem_write_en", mem_write_en, exp_wr);
      if (exp_rd || exp_wr) check_eq("mem_addr", mem_addr, cur.addr & ADDR_MASK);
      if (exp_wr) check_eq("mem_wdata", mem_write_data, ref_store(ref_mem[idx], cur));
      if (r) begin
         check_eq("rst_mem_addr", mem_addr, 32'd0);
         check_eq("rst_mem_wdata", mem_write_data, 32'd0);
      end

      if (c_rsp_valid) begin c_rsp_cyc = cyc; c_rsp_n++; c_last_rdata = c_rsp_rdata; c_last_err = c_rsp_err; end
      if (d_rsp_valid) begin d_rsp_cyc = cyc; d_rsp_n++; end
      if (mem_read)     rd_n++;
      if (mem_write_en) begin wr_n++; w_last = mem_write_data; end

      if (r) begin
         act = 1'b0; starve = 0;
      end else begin
         if (exp_rsp) begin
            if (exp_wr) ref_mem[idx] = ref_store(ref_mem[idx], cur);
            act = 1'b0;
         end else if (act) begin
            k++;
         end
         if (exp_cr || exp_dr) begin
            cur      = exp_dr ? dr : cr;
            cur.port = exp_dr;
            cur_err  = ref_err(cur);
            lat      = (cur_err || (cur.we && cur.size == 2'd2)) ? 1 : 2;
            act      = 1'b1;
            k        = 1;
            acc_port_log.push_back(int'(exp_dr));
            acc_cyc_log.push_back(cyc);
            if (exp_dr) void'(dq.pop_front());
            else        void'(cq.pop_front());
         end
         if (exp_dr) starve = 0;
         else if (dv && starve < STARVE_LIMIT) starve++;
      end
      @(posedge clk);
      #1;
      cyc++;
      init_en = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((cq.size() > 0 || dq.size() > 0 || act) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain", 32'(cq.size() + dq.size() + int'(act)), 32'd0);
   endtask

   initial begin
      int a, wr0, rd0, rsp0;
      int exp_order[8];
      checks_cnt = 0; errors_cnt = 0; cyc = 0; act = 1'b0; starve = 0;
      rst_hold = 1'b1; rst_at = -1; c_rsp_n = 0; d_rsp_n = 0; rd_n = 0; wr_n = 0;
      for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = init_word(i);
      repeat (3) tick();
      rst_hold = 1'b0;
      tick();

      // Word load of the power-up word at 0x4
      cq.push_back(mk(1'b0, 2'd2, 32'h4, 32'd0));
      drain(20);
      check_eq("wload_lat", 32'(c_rsp_cyc - acc_cyc_log[$]), 32'd2);
      check_eq("wload_data", c_last_rdata, 32'hDEAD_BEEF);
      check_eq("wload_err", c_last_err, 1'b0);

      // Byte store merge, then read back
      cq.push_back(mk(1'b1, 2'd0, 32'h9, 32'h0000_0055));
      drain(20);
      check_eq("bstore_lat", 32'(c_rsp_cyc - acc_cyc_log[$]), 32'd2);
      check_eq("bstore_wdata", w_last, 32'hCAFE_55BE);
      cq.push_back(mk(1'b0, 2'd2, 32'h8, 32'd0));
      drain(20);
      check_eq("bstore_readback", c_last_rdata, 32'hCAFE_55BE);

      // Misaligned half load: error after one cycle, no memory traffic
      rd0 = rd_n; wr0 = wr_n;
      cq.push_back(mk(1'b0, 2'd1, 32'h3, 32'd0));
      drain(20);
      check_eq("mis_lat", 32'(c_rsp_cyc - acc_cyc_log[$]), 32'd1);
      check_eq("mis_err", c_last_err, 1'b1);
      check_eq("mis_rdata", c_last_rdata, 32'd0);
      check_eq("mis_noread", 32'(rd_n), 32'(rd0));
      check_eq("mis_nowrite", 32'(wr_n), 32'(wr0));

      // Starvation: C saturates the bus until D is force-granted
      acc_port_log.delete(); acc_cyc_log.delete();
      for (int i = 0; i < 6; i++) cq.push_back(mk(1'b1, 2'd2, 32'h100 + 32'(4*i), 32'(i)));
      dq.push_back(mk(1'b1, 2'd2, 32'h200, 32'h1234_5678));
      dq.push_back(mk(1'b1, 2'd2, 32'h204, 32'h8765_4321));
      drain(100);
      exp_order = '{0, 0, 0, 0, 1, 0, 0, 1};
      check_eq("starve_n", 32'(acc_port_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < acc_port_log.size(); i++)
         check_eq($sformatf("starve_order%0d", i), 32'(acc_port_log[i]), 32'(exp_order[i]));
      if (acc_cyc_log.size() > 4)
         check_eq("starve_d_cycle", 32'(acc_cyc_log[4] - acc_cyc_log[0]), 32'd8);

      // Reset during MERGE_WR of a half store to 0x28
      wr0 = wr_n; rsp0 = c_rsp_n;
      rst_at = cyc + 2;
      cq.push_back(mk(1'b1, 2'd1, 32'h28, 32'h0000_ABCD));
      drain(20);
      tick();
      check_eq("rstmerge_nowrite", 32'(wr_n), 32'(wr0));
      check_eq("rstmerge_norsp", 32'(c_rsp_n), 32'(rsp0));
      cq.push_back(mk(1'b0, 2'd2, 32'h28, 32'd0));
      drain(20);
      check_eq("rstmerge_readback", c_last_rdata, 32'd50);

      // Simultaneous word stores from both ports
      acc_port_log.delete(); acc_cyc_log.delete();
      cq.push_back(mk(1'b1, 2'd2, 32'h40, 32'h1111_1111));
      dq.push_back(mk(1'b1, 2'd2, 32'h44, 32'h2222_2222));
      drain(20);
      check_eq("sim_n", 32'(acc_port_log.size()), 32'd2);
      if (acc_port_log.size() == 2) begin
         a = acc_cyc_log[0];
         check_eq("sim_first_c", 32'(acc_port_log[0]), 32'd0);
         check_eq("sim_then_d", 32'(acc_port_log[1]), 32'd1);
         check_eq("sim_c_rsp", 32'(c_rsp_cyc - a), 32'd1);
         check_eq("sim_d_acc", 32'(acc_cyc_log[1] - a), 32'd2);
         check_eq("sim_d_rsp", 32'(d_rsp_cyc - a), 32'd3);
      end

      // Randomized two-port traffic with occasional resets
      for (int n = 0; n < 4000; n++) begin
         if (cq.size() < 2 && $urandom_range(0, 9) < 3)
            cq.push_back(mk(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                            32'($urandom_range(0, 255)), $urandom));
         if (dq.size() < 2 && $urandom_range(0, 9) < 2)
            dq.push_back(mk(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                            32'($urandom_range(0, 255)), $urandom));
         if ($urandom_range(0, 299) == 0) rst_at = cyc;
         tick();
      end
      drain(200);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
